// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA peripheral datapath blocks.
// Holds the Montgomery FSM state encoding, the default width and a ceil-log2 helper.
package rsa_pkg;

  localparam int MONT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CORRECT = 2'd2,
    FINISH  = 2'd3
  } mont_state_t;

  // Smallest n with 2**n >= v; a floor of 1 keeps counters at least one bit wide.
  function automatic int clog2(input int v);
    int n;
    n = 1;
    while ((1 << n) < v) n++;
    return n;
  endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: adds a_i*B and q_i*M to r, then halves.
// Purely combinational; the sum is WIDTH+2 bits wide so it never overflows while r < 2M.
module mont_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             aBit_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   rNext_o,
  output logic             q_o
);

  logic [WIDTH+1:0] sum;

  // q_i forces the sum even, so the halving below is exact.
  assign q_o = r_i[0] ^ (aBit_i & b_i[0]);

  assign sum = {1'b0, r_i}
             + (aBit_i ? {2'b00, b_i} : '0)
             + (q_o    ? {2'b00, m_i} : '0);

  assign rNext_o = (WIDTH+1)'(sum >> 1);

endmodule

// File: rtl/mont_mult_serial.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M, one bit of A per clock.
// Define MONT_OPERAND_CHECK_EN to reject even M or A/B >= M with err and a fast done.
module mont_mult_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mont_state_t      state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, m_q, result_q;
  logic [WIDTH:0]   r_q, rNext_d, rMinus_d;
  logic             busy_q, done_q, qBit, unusedQ, abort;

  mont_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .aBit_i  (a_q[0]),
    .b_i     (b_q),
    .m_i     (m_q),
    .rNext_o (rNext_d),
    .q_o     (qBit)
  );

  assign unusedQ  = qBit;
  assign rMinus_d = r_q - {1'b0, m_q};

`ifdef MONT_OPERAND_CHECK_EN
  logic operandBad, err_q;
  assign operandBad = ~m_in[0] | (a_in >= m_in) | (b_in >= m_in);
  assign abort      = err_q;
  assign err        = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // A is consumed LSB-first by shifting a_q; cnt_q only decides when the last bit is done.
  // A rejected operand set spends one RUN cycle and then jumps straight to FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MONT_OPERAND_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            m_q     <= m_in;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef MONT_OPERAND_CHECK_EN
            err_q   <= operandBad;
            if (operandBad) result_q <= '0;
`endif
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= FINISH;
          end else begin
            r_q <= rNext_d;
            a_q <= a_q >> 1;
            if (cnt_q == LAST_CNT) state_q <= CORRECT;
            else                   cnt_q   <= cnt_q + CW'(1);
          end
        end
        CORRECT: begin
          result_q <= (r_q >= {1'b0, m_q}) ? WIDTH'(rMinus_d) : WIDTH'(r_q);
          state_q  <= FINISH;
        end
        FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mont_mult_serial.sv
// Self-checking bench for mont_mult_serial: WIDTH=4 directed vectors plus a WIDTH=8 random sweep.
// Honours MONT_OPERAND_CHECK_EN when the design is built with it.
module tb_mont_mult_serial;

  typedef struct {
    int a;
    int b;
    int m;
    int expRes;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, b4, m4, res4;
  logic [7:0] a8, b8, m8, res8;
  logic       busy4, done4, err4, busy8, done8, err8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mont_mult_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .m_in(m4),
    .busy(busy4), .done(done4), .result(res4), .err(err4)
  );

  mont_mult_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .m_in(m8),
    .busy(busy8), .done(done8), .result(res8), .err(err8)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Called just after a rising edge; returns result, edges from accept to done, busy sanity.
  task automatic applyStimulus(input int sel, input int a, input int b, input int m,
                               output int res, output int lat, output bit busyOk);
    bit dn, bz;
    if (sel == 0) begin
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; m4 = m[3:0];
    end else begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; m8 = m[7:0];
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
    busyOk = (sel == 0) ? busy4 : busy8;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      dn = (sel == 0) ? done4 : done8;
      bz = (sel == 0) ? busy4 : busy8;
      if (dn) begin
        lat = c;
        if (bz) busyOk = 1'b0;
        break;
      end
      if (!bz) busyOk = 1'b0;
    end
    res = (sel == 0) ? int'(res4) : int'(res8);
  endtask

  initial begin
    vec_t vecs[$];
    int   res, lat, dones, inv, expv, am, bm, mm;
    bit   bOk;

    vecs.push_back('{7, 5, 13, 3});
    vecs.push_back('{12, 12, 13, 9});
    vecs.push_back('{0, 9, 13, 0});
    vecs.push_back('{5, 7, 13, 3});
    vecs.push_back('{1, 1, 13, 9});
    vecs.push_back('{2, 3, 11, 10});
    vecs.push_back('{14, 14, 15, 1});
    vecs.push_back('{2, 2, 3, 1});

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; m4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset busy", busy4, 0);
    checkOutput("reset done", done4, 0);
    checkOutput("reset result", res4, 0);
    checkOutput("reset err", err4, 0);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].m, res, lat, bOk);
      checkOutput($sformatf("vec%0d result", i), res, vecs[i].expRes);
      checkOutput($sformatf("vec%0d latency", i), lat, 6);
      checkOutput($sformatf("vec%0d busy", i), bOk, 1);
    end

    // A second start mid-run must be ignored along with its operands.
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd5; m4 = 4'd13;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 start4 = 1'b1; a4 = 4'd12; b4 = 4'd12; m4 = 4'd11;
    @(posedge clk); #1 start4 = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done4) dones++;
      @(posedge clk); #1;
    end
    checkOutput("busy-start dones", dones, 1);
    checkOutput("busy-start result", res4, 3);

    // Reset during RUN at cnt=2 abandons the run without a done pulse.
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd12; m4 = 4'd13;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checkOutput("midreset busy", busy4, 0);
    checkOutput("midreset result", res4, 0);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done4) dones++;
      @(posedge clk); #1;
    end
    checkOutput("midreset dones", dones, 0);
    applyStimulus(0, 7, 5, 13, res, lat, bOk);
    checkOutput("post-reset result", res, 3);
    checkOutput("post-reset latency", lat, 6);

`ifdef MONT_OPERAND_CHECK_EN
    applyStimulus(0, 7, 5, 12, res, lat, bOk);
    checkOutput("even M err", err4, 1);
    checkOutput("even M result", res, 0);
    checkOutput("even M latency", lat, 2);
    applyStimulus(0, 13, 5, 13, res, lat, bOk);
    checkOutput("A>=M err", err4, 1);
    checkOutput("A>=M latency", lat, 2);
    applyStimulus(0, 7, 5, 13, res, lat, bOk);
    checkOutput("valid clears err", err4, 0);
    checkOutput("valid after err result", res, 3);
`else
    applyStimulus(0, 7, 5, 12, res, lat, bOk);
    checkOutput("even M err", err4, 0);
    checkOutput("even M latency", lat, 6);
`endif

    // Reference: (A*B mod M) * inverse(256) mod M, inverse found by search.
    for (int n = 0; n < 1000; n++) begin
      mm = 2 * $urandom_range(127, 1) + 1;
      am = $urandom_range(mm - 1, 0);
      bm = $urandom_range(mm - 1, 0);
      inv = 0;
      for (int k = 1; k < mm; k++) begin
        if (((256 * k) % mm) == 1) begin
          inv = k;
          break;
        end
      end
      expv = (((am * bm) % mm) * inv) % mm;
      applyStimulus(1, am, bm, mm, res, lat, bOk);
      checkOutput($sformatf("rand%0d A=%0d B=%0d M=%0d result", n, am, bm, mm), res, expv);
      checkOutput($sformatf("rand%0d latency", n), lat, 10);
    end
    checkOutput("w8 err", err8, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
